mem_port_arbiter: RTL

Sequencer for a single-ported, fixed-latency unified memory shared between the instruction-fetch stage and the data-memory stage of the 5-stage pipeline. It grants one of the two requesters and issues the access to memory. It then counts out the memory latency and returns a one-cycle done pulse with read data to the winner. It also drives the per-stage stall signals that freeze the pipeline while an access is outstanding.

---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/mem_arb_timer.sv | 56 +++++
 rtl/mem_port_arbiter.sv | 128 ++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the IF/DM unified-memory port arbiter.
package mem_arb_pkg;

  typedef enum logic {IDLE, WAIT} state_e;
  typedef enum logic {OWN_IF, OWN_DM} owner_e;

  localparam int ADDR_W_DEF       = 32;
  localparam int DATA_W_DEF       = 32;
  localparam int MEM_LAT_DEF      = 2;
  localparam int STARVE_LIMIT_DEF = 4;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/mem_arb_timer.sv
// Latency down-counter with zero flag, plus saturating
// counter of consecutive data grants taken while a fetch waits.
module mem_arb_timer
  import mem_arb_pkg::*;
#(
  parameter int MEM_LAT      = MEM_LAT_DEF,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic load,
  input  logic dec,
  input  logic s_clr,
  input  logic s_inc,
  output logic cnt_zero,
  output logic starve_hit
);

  localparam int CW = clog2(MEM_LAT);
  localparam int SW = clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(MEM_LAT - 1);
  localparam logic [SW-1:0] S_MAX    = SW'(STARVE_LIMIT);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] starve_q, starve_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)
      cnt_d = CNT_INIT;
    else if (dec && cnt_q != '0)
      cnt_d = cnt_q - 1'b1;
  end

  always_comb begin
    starve_d = starve_q;
    if (s_clr)
      starve_d = '0;
    else if (s_inc && starve_q != S_MAX)
      starve_d = starve_q + 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q    <= '0;
      starve_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      starve_q <= starve_d;
    end
  end

  assign cnt_zero   = (cnt_q == '0);
  assign starve_hit = (starve_q == S_MAX);

endmodule

// File: rtl/mem_port_arbiter.sv
// Grants the shared single-ported memory to fetch or data stage,
// times the fixed latency and returns done/rdata plus stalls.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int MEM_LAT      = MEM_LAT_DEF,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_done,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_stall,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_done,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_stall,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_e state_q, state_d;
  owner_e owner_q, owner_d;
  logic   kill_q, kill_d;
  logic   st_q, st_d;

  logic cnt_zero, starve_hit;
  logic idle, fin, live;
  logic if_elig, dm_elig;
  logic grant_if, grant_dm, issue;
  logic if_fin, dm_fin, kill_now;

  assign live = ~reset;
  assign idle = (state_q == IDLE);
  assign fin  = (state_q == WAIT) && cnt_zero;

  // At completion only the other port may be issued back-to-back.
  assign if_elig = if_req && !if_flush &&
                   (idle || (fin && owner_q == OWN_DM));
  assign dm_elig = dm_req &&
                   (idle || (fin && owner_q == OWN_IF));

  assign grant_if = if_elig && (!dm_elig || starve_hit);
  assign grant_dm = dm_elig && !grant_if;
  assign issue    = grant_if || grant_dm;

  assign if_fin   = fin && owner_q == OWN_IF;
  assign dm_fin   = fin && owner_q == OWN_DM;
  assign kill_now = kill_q || (if_fin && if_flush);

  mem_arb_timer #(
    .MEM_LAT      (MEM_LAT),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_timer (
    .clock      (clock),
    .reset      (reset),
    .load       (issue),
    .dec        (state_q == WAIT),
    .s_clr      (!if_req || grant_if),
    .s_inc      (grant_dm && if_req),
    .cnt_zero   (cnt_zero),
    .starve_hit (starve_hit)
  );

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    kill_d  = kill_q;
    st_d    = st_q;
    if (issue) begin
      state_d = WAIT;
      owner_d = grant_if ? OWN_IF : OWN_DM;
      st_d    = grant_dm && dm_we;
    end else if (fin) begin
      state_d = IDLE;
    end
    if (fin)
      kill_d = 1'b0;
    else if (state_q == WAIT && owner_q == OWN_IF && if_flush)
      kill_d = 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= OWN_IF;
      kill_q  <= 1'b0;
      st_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      kill_q  <= kill_d;
      st_q    <= st_d;
    end
  end

  always_comb begin
    mem_en    = live && issue;
    mem_we    = live && grant_dm && dm_we;
    mem_addr  = '0;
    mem_wdata = '0;
    if (live && grant_if)
      mem_addr = if_addr;
    else if (live && grant_dm) begin
      mem_addr  = dm_addr;
      mem_wdata = dm_we ? dm_wdata : '0;
    end
  end

  assign if_done  = live && if_fin && !kill_now;
  assign dm_done  = live && dm_fin;
  assign if_rdata = if_done ? mem_rdata : '0;
  assign dm_rdata = (dm_done && !st_q) ? mem_rdata : '0;
  assign if_stall = live && if_req && !if_done;
  assign dm_stall = live && dm_req && !dm_done;

endmodule
